ibex_aes_col_seq: RTL and testbench

Multi-cycle sequencer and arbiter for the shared combinational AES round unit (`aes_unit`) in the EX block. It computes one full AES round output column by driving the unit four times, with byte selects 0..3, and XOR-accumulating the results into a column register seeded with the round key. Single-cycle AES instructions from the core share the same unit and always win arbitration; the sequence stalls around them. The block sits beside the ALU in the EX block, between the decoder/controller request signals and the `aes_unit` operand ports.

---
 rtl/ibex_aes_col_seq.sv | 133 +++++++++++++
 tb/tb_ibex_aes_col_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_aes_col_seq.sv
// ibex_aes_col_seq
//
// Multi-cycle sequencer and arbiter for the shared combinational AES round
// unit. A column request drives the unit four times (byte selects 0..3),
// XOR-accumulating each result into a column register seeded with the round
// key. Single-cycle core AES instructions always win the unit; the column
// sequence simply stalls for that cycle.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   core_req_i/mix/bs/rs*   single-cycle core AES instruction in EX
//   core_rd_o               core result (combinational from aes_rd_i)
//   seq_valid_i/ready_o     column request handshake
//   seq_mix_i/key_i/state_i column request payload (mix flag, key, 4 words)
//   seq_kill_i              flush, aborts any sequence
//   seq_out_valid_o/ready_i column result handshake
//   seq_result_o            column result (accumulator register)
//   busy_o                  sequencer not idle
//   aes_*_o / aes_rd_i      operand and result ports of the aes_unit
module ibex_aes_col_seq #(
    parameter bit ZeroIdle = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         core_req_i,
    input  logic         core_mix_i,
    input  logic [1:0]   core_bs_i,
    input  logic [31:0]  core_rs1_i,
    input  logic [31:0]  core_rs2_i,
    output logic [31:0]  core_rd_o,
    input  logic         seq_valid_i,
    output logic         seq_ready_o,
    input  logic         seq_mix_i,
    input  logic [31:0]  seq_key_i,
    input  logic [127:0] seq_state_i,
    input  logic         seq_kill_i,
    output logic         seq_out_valid_o,
    input  logic         seq_out_ready_i,
    output logic [31:0]  seq_result_o,
    output logic         busy_o,
    output logic         aes_en_o,
    output logic         aes_mix_o,
    output logic [1:0]   aes_bs_o,
    output logic [31:0]  aes_rs1_o,
    output logic [31:0]  aes_rs2_o,
    input  logic [31:0]  aes_rd_i
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q;
    logic [1:0]     step_q;
    logic [31:0]    acc_q;
    logic           mix_q;
    logic [127:0]   words_q;
    logic [31:0]    cur_word;

    assign cur_word = words_q[{step_q, 5'd0} +: 32];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            acc_q   <= 32'd0;
            mix_q   <= 1'b0;
            words_q <= 128'd0;
        end else if (seq_kill_i) begin
            // Flush beats accept, advance and the output handshake; acc is kept.
            state_q <= StIdle;
            step_q  <= 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (seq_valid_i) begin
                        mix_q   <= seq_mix_i;
                        words_q <= seq_state_i;
                        acc_q   <= seq_key_i;
                        step_q  <= 2'd0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    // A core request owns the unit this cycle, so hold acc/step.
                    if (!core_req_i) begin
                        acc_q <= aes_rd_i;
                        if (step_q == 2'd3) begin
                            step_q  <= 2'd0;
                            state_q <= StDone;
                        end else begin
                            step_q <= step_q + 2'd1;
                        end
                    end
                end
                StDone: begin
                    if (seq_out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        aes_en_o  = 1'b0;
        aes_mix_o = mix_q;
        aes_bs_o  = step_q;
        aes_rs1_o = acc_q;
        aes_rs2_o = cur_word;
        if (core_req_i) begin
            aes_en_o  = 1'b1;
            aes_mix_o = core_mix_i;
            aes_bs_o  = core_bs_i;
            aes_rs1_o = core_rs1_i;
            aes_rs2_o = core_rs2_i;
        end else if (state_q == StRun) begin
            aes_en_o = 1'b1;
        end else if (ZeroIdle) begin
            // Keep the unit's inputs quiet while it is not in use.
            aes_mix_o = 1'b0;
            aes_bs_o  = 2'd0;
            aes_rs1_o = 32'd0;
            aes_rs2_o = 32'd0;
        end
    end

    assign core_rd_o       = aes_rd_i;
    assign seq_ready_o     = (state_q == StIdle) && !seq_kill_i;
    assign seq_out_valid_o = (state_q == StDone);
    assign seq_result_o    = acc_q;
    assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_ibex_aes_col_seq.sv
module tb_ibex_aes_col_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_req, core_mix;
    logic [1:0]   core_bs;
    logic [31:0]  core_rs1, core_rs2, core_rd;
    logic         seq_valid, seq_ready, seq_mix, seq_kill;
    logic [31:0]  seq_key;
    logic [127:0] seq_state;
    logic         seq_out_valid, seq_out_ready;
    logic [31:0]  seq_result;
    logic         busy, aes_en, aes_mix;
    logic [1:0]   aes_bs;
    logic [31:0]  aes_rs1, aes_rs2, aes_rd;

    int total = 0;
    int bad = 0;
    logic [31:0] sb[$];

    localparam logic [127:0] Words = {32'h8888_8888, 32'h4444_4444,
                                      32'h2222_2222, 32'h1111_1111};

    ibex_aes_col_seq #(.ZeroIdle(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_mix_i(core_mix), .core_bs_i(core_bs),
        .core_rs1_i(core_rs1), .core_rs2_i(core_rs2), .core_rd_o(core_rd),
        .seq_valid_i(seq_valid), .seq_ready_o(seq_ready), .seq_mix_i(seq_mix),
        .seq_key_i(seq_key), .seq_state_i(seq_state), .seq_kill_i(seq_kill),
        .seq_out_valid_o(seq_out_valid), .seq_out_ready_i(seq_out_ready),
        .seq_result_o(seq_result), .busy_o(busy),
        .aes_en_o(aes_en), .aes_mix_o(aes_mix), .aes_bs_o(aes_bs),
        .aes_rs1_o(aes_rs1), .aes_rs2_o(aes_rs2), .aes_rd_i(aes_rd)
    );

    // aes_unit stand-in
    assign aes_rd = aes_rs1 ^ aes_rs2 ^ {30'b0, aes_bs};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] key, input logic [127:0] st);
        logic [31:0] a;
        a = key;
        for (int i = 0; i < 4; i++) a = a ^ st[32*i +: 32] ^ 32'(i);
        return a;
    endfunction

    // Issue one column request; core_at selects a RUN cycle index carrying a core op
    // (-1 for none). Returns at the negedge of the first DONE cycle.
    task automatic run_seq(input string tag, input logic [31:0] key, input logic m,
                           input int core_at, input int exp_lat);
        int cyc;
        int step;
        logic got;
        @(negedge clk);
        check({tag, "_ready"}, seq_ready, 1);
        seq_valid = 1; seq_key = key; seq_state = Words; seq_mix = m;
        sb.push_back(model(key, Words));
        @(posedge clk); #1 seq_valid = 0;
        cyc = 0; step = 0; got = 0;
        while (!got && cyc < 20) begin
            if (cyc == core_at) begin
                core_req = 1; core_mix = 1; core_bs = 2'd2;
                core_rs1 = 32'hDEAD_BEEF; core_rs2 = 32'h1234_5678;
            end else begin
                core_req = 0;
            end
            @(negedge clk);
            if (seq_out_valid) begin
                got = 1;
            end else begin
                check({tag, "_run_ready"}, seq_ready, 0);
                check({tag, "_run_en"}, aes_en, 1);
                if (core_req) begin
                    check({tag, "_core_bs"}, aes_bs, core_bs);
                    check({tag, "_core_rs1"}, aes_rs1, core_rs1);
                    check({tag, "_core_rs2"}, aes_rs2, core_rs2);
                    check({tag, "_core_mix"}, aes_mix, core_mix);
                    check({tag, "_core_rd"}, core_rd, core_rs1 ^ core_rs2 ^ {30'b0, core_bs});
                end else begin
                    check({tag, "_bs"}, aes_bs, step[1:0]);
                    check({tag, "_mix"}, aes_mix, m);
                    step++;
                end
                cyc++;
                @(posedge clk); #1;
            end
        end
        core_req = 0;
        check({tag, "_got_valid"}, got, 1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_steps"}, step, 4);
        if (got && sb.size() > 0) check({tag, "_result"}, seq_result, sb.pop_front());
    endtask

    initial begin
        logic [31:0] held;
        rst = 1; core_req = 0; core_mix = 0; core_bs = 0; core_rs1 = 0; core_rs2 = 0;
        seq_valid = 0; seq_mix = 0; seq_key = 0; seq_state = 0; seq_kill = 0;
        seq_out_ready = 1;

        // Reset state and idle gating
        repeat (2) @(negedge clk);
        check("rst_ready", seq_ready, 1);
        check("rst_valid", seq_out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", seq_result, 0);
        check("rst_en", aes_en, 0);
        check("rst_rs1", aes_rs1, 0);
        rst = 0;

        // Core op while idle: passes straight through, then gating returns
        @(negedge clk);
        core_req = 1; core_mix = 1; core_bs = 2'd3; core_rs1 = 32'hA5A5_0000; core_rs2 = 32'h0000_5A5A;
        #1;
        check("idle_core_en", aes_en, 1);
        check("idle_core_rs1", aes_rs1, 32'hA5A5_0000);
        check("idle_core_rd", core_rd, 32'hA5A5_5A59);
        core_req = 0;
        #1;
        check("gate_en", aes_en, 0);
        check("gate_rs1", aes_rs1, 0);
        check("gate_rs2", aes_rs2, 0);
        check("gate_bs", aes_bs, 0);
        check("gate_mix", aes_mix, 0);

        // Basic column, then back-to-back with a core op in the second RUN cycle
        run_seq("basic", 32'h0000_00FF, 1, -1, 4);
        run_seq("contend", 32'h0000_00FF, 1, 1, 5);
        run_seq("final_rnd", 32'hCAFE_0001, 0, -1, 4);

        // Back-to-back: the cycle after DONE->IDLE is idle and gated again
        @(negedge clk);
        check("b2b_idle_busy", busy, 0);
        check("b2b_idle_en", aes_en, 0);

        // Backpressure in DONE
        seq_out_ready = 0;
        run_seq("bp", 32'h1357_9BDF, 1, -1, 4);
        held = model(32'h1357_9BDF, Words);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_valid", seq_out_valid, 1);
            check("bp_result", seq_result, held);
            check("bp_ready", seq_ready, 0);
        end
        seq_out_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_valid", seq_out_valid, 0);
        check("bp_idle_ready", seq_ready, 1);

        // Kill at step 2 together with a new request
        @(negedge clk);
        seq_valid = 1; seq_key = 32'h0F0F_0F0F; seq_state = Words; seq_mix = 1;
        @(posedge clk); #1 seq_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        seq_kill = 1; seq_valid = 1; seq_key = 32'h7777_7777;
        @(negedge clk);
        check("kill_bs", aes_bs, 2);
        check("kill_ready", seq_ready, 0);
        @(posedge clk); #1 seq_kill = 0; seq_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("kill_busy", busy, 0);
            check("kill_valid", seq_out_valid, 0);
        end

        // Asynchronous reset mid-RUN
        @(negedge clk);
        seq_valid = 1; seq_key = 32'h2468_ACE0; seq_state = Words; seq_mix = 1;
        @(posedge clk); #1 seq_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rrun_bs", aes_bs, 1);
        #2 rst = 1;
        #1;
        check("rrun_busy", busy, 0);
        check("rrun_valid", seq_out_valid, 0);
        check("rrun_en", aes_en, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rrun_ready", seq_ready, 1);
        check("rrun_result", seq_result, 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
